// File: rtl/axi_output_adapter.sv
// AXI-Stream transmit adapter: captures an N x N accumulator matrix, saturates each
// element to OUT_W bits and streams it row-major with tlast on the final beat.
module axi_output_adapter #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    results_valid,
  input  logic signed [ACC_W-1:0] c_in [N][N],
  output logic                    m_axis_tvalid,
  output logic signed [OUT_W-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic                    drop
);

  localparam int NB    = N * N;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        beat_cnt_reg;
  logic [CNT_W-1:0]        beat_cnt_next;
  logic signed [OUT_W-1:0] buf_reg [NB];
  logic signed [OUT_W-1:0] sat_val [NB];

  logic                    tvalid_reg;
  logic signed [OUT_W-1:0] tdata_reg;
  logic                    tlast_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    drop_reg;

  // An element fits in OUT_W bits exactly when every bit from OUT_W-1 up to the sign agrees.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_sat
      logic signed [ACC_W-1:0] x;
      logic [ACC_W-OUT_W:0]    upper;
      assign x     = c_in[gi / N][gi % N];
      assign upper = x[ACC_W-1:OUT_W-1];
      assign sat_val[gi] = ((&upper) || !(|upper)) ? x[OUT_W-1:0] :
                           x[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                        {1'b0, {(OUT_W-1){1'b1}}};
    end
  endgenerate

  assign beat_cnt_next = beat_cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      tvalid_reg   <= 1'b0;
      tdata_reg    <= '0;
      tlast_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      drop_reg     <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        buf_reg[i] <= '0;
      end
    end else begin
      done_reg <= 1'b0;
      drop_reg <= results_valid && !((state_reg == IDLE) && enable);
      case (state_reg)
        IDLE: begin
          if (results_valid && enable) begin
            for (int i = 0; i < NB; i++) begin
              buf_reg[i] <= sat_val[i];
            end
            beat_cnt_reg <= '0;
            tvalid_reg   <= 1'b1;
            tdata_reg    <= sat_val[0];
            tlast_reg    <= (NB == 1);
            busy_reg     <= 1'b1;
            state_reg    <= STREAM;
          end
        end
        STREAM: begin
          // tvalid is held high for the whole state, so tready alone marks the handshake.
          if (m_axis_tready) begin
            if (beat_cnt_reg == LAST_IDX) begin
              beat_cnt_reg <= '0;
              tvalid_reg   <= 1'b0;
              tlast_reg    <= 1'b0;
              done_reg     <= 1'b1;
              state_reg    <= DONE;
            end else begin
              beat_cnt_reg <= beat_cnt_next;
              tdata_reg    <= buf_reg[beat_cnt_next];
              tlast_reg    <= (beat_cnt_next == LAST_IDX);
            end
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg   <= 1'b0;
          tvalid_reg <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tlast  = tlast_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign drop          = drop_reg;

endmodule

// File: tb/tb_axi_output_adapter.sv
// Scoreboard bench for axi_output_adapter: expected beats are queued at capture and
// compared against beats recorded on the AXI-Stream port.
module tb_axi_output_adapter;

  localparam int N     = 4;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int NB    = N * N;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    enable = 1'b0;
  logic                    results_valid = 1'b0;
  logic signed [ACC_W-1:0] c_in [N][N];
  logic                    m_axis_tvalid;
  logic signed [OUT_W-1:0] m_axis_tdata;
  logic                    m_axis_tlast;
  logic                    m_axis_tready = 1'b1;
  logic                    busy;
  logic                    done;
  logic                    drop;

  axi_output_adapter #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .results_valid (results_valid),
    .c_in          (c_in),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done),
    .drop          (drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_data[$];
  bit exp_last[$];
  int obs_data[$];
  bit obs_last[$];
  int obs_cyc[$];
  int done_q[$];
  int drop_q[$];
  int stab_err = 0;
  int rdy_mode = 0;

  // tready pattern: 0 = always high, 1 = toggling, 2 = random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  bit                      prev_stall = 1'b0;
  logic signed [OUT_W-1:0] prev_data;
  logic                    prev_last;
  always @(negedge clk) begin
    if (prev_stall && !rst &&
        (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
      stab_err++;
    prev_stall = m_axis_tvalid && !m_axis_tready && !rst;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      obs_data.push_back(int'(m_axis_tdata));
      obs_last.push_back(m_axis_tlast);
      obs_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_q.push_back(cyc);
    if (drop === 1'b1) drop_q.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, required finish earlier", cyc);
    $fatal(1);
  end

  function automatic int sat_model(longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  task automatic set_matrix(input int base, input int step);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        c_in[r][c] = base + (r * N + c) * step;
  endtask

  task automatic push_expected();
    for (int i = 0; i < NB; i++) begin
      exp_data.push_back(sat_model(longint'(c_in[i / N][i % N])));
      exp_last.push_back(i == NB - 1);
    end
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    done_q.delete(); drop_q.delete(); exp_data.delete(); exp_last.delete();
    stab_err = 0;
  endtask

  task automatic pulse_rv(input bit en, output int edge_no);
    @(posedge clk); #1;
    results_valid = 1'b1;
    enable = en;
    @(posedge clk); #1;
    edge_no = cyc;
    results_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b, required 0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tdata !== '0) begin n_bad++; $display("FAIL reset_tdata: got %0d, required 0", m_axis_tdata); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %b, required 0", m_axis_tlast); end
    n_cmp++; if ({busy, done, drop} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got busy/done/drop %b, required 000", {busy, done, drop}); end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_basic();
    int  cap;
    bit  ok;
    clear_obs();
    rdy_mode = 0;
    set_matrix(0, 1);
    push_expected();
    pulse_rv(1'b1, cap);
    wait_idle(ok);
    repeat (2) @(negedge clk);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout: got busy stuck, required idle"); end
    n_cmp++; if (obs_data.size() != NB) begin n_bad++; $display("FAIL basic_count: got %0d beats, required %0d", obs_data.size(), NB); end
    n_cmp++; if (obs_cyc.size() > 0 && obs_cyc[0] != cap) begin n_bad++; $display("FAIL basic_first_cycle: got %0d, required %0d", obs_cyc[0], cap); end
    n_cmp++; if (obs_cyc.size() == NB && obs_cyc[NB-1] != cap + NB - 1) begin n_bad++; $display("FAIL basic_last_cycle: got %0d, required %0d", obs_cyc[NB-1], cap + NB - 1); end
    n_cmp++; if (done_q.size() != 1 || done_q[0] != cap + NB) begin n_bad++; $display("FAIL basic_done: got %0d pulses (first at %0d), required 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, cap + NB); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      int  ed = exp_data.pop_front(); bit el = exp_last.pop_front();
      int  od = obs_data.pop_front(); bit ol = obs_last.pop_front();
      n_cmp++; if (od != ed || ol != el) begin n_bad++; $display("FAIL basic_beat: got data %0d last %b, required data %0d last %b", od, ol, ed, el); end
    end
    $display("basic: frame captured at edge %0d streamed with tready high", cap);
  endtask

  task automatic test_backpressure();
    int cap;
    bit ok;
    for (int mode = 1; mode <= 2; mode++) begin
      clear_obs();
      rdy_mode = mode;
      set_matrix(0, 1);
      push_expected();
      pulse_rv(1'b1, cap);
      wait_idle(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_timeout mode %0d: got busy stuck, required idle", mode); end
      n_cmp++; if (obs_data.size() != NB) begin n_bad++; $display("FAIL bp_count mode %0d: got %0d beats, required %0d", mode, obs_data.size(), NB); end
      n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL bp_stable mode %0d: got %0d unstable stalls, required 0", mode, stab_err); end
      while (exp_data.size() > 0 && obs_data.size() > 0) begin
        int  ed = exp_data.pop_front(); bit el = exp_last.pop_front();
        int  od = obs_data.pop_front(); bit ol = obs_last.pop_front();
        n_cmp++; if (od != ed || ol != el) begin n_bad++; $display("FAIL bp_beat mode %0d: got data %0d last %b, required data %0d last %b", mode, od, ol, ed, el); end
      end
      $display("backpressure: frame with tready mode %0d complete", mode);
    end
    rdy_mode = 0;
  endtask

  task automatic test_saturation();
    int cap;
    bit ok;
    clear_obs();
    rdy_mode = 0;
    set_matrix(-50000, 7001);
    c_in[0][0] = 70000;
    c_in[0][1] = -70000;
    c_in[0][2] = 32767;
    c_in[0][3] = -32768;
    c_in[1][0] = 32768;
    c_in[1][1] = -32769;
    c_in[1][2] = -1;
    c_in[1][3] = 32'h7fffffff;
    push_expected();
    pulse_rv(1'b1, cap);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sat_timeout: got busy stuck, required idle"); end
    n_cmp++; if (obs_data.size() != NB) begin n_bad++; $display("FAIL sat_count: got %0d beats, required %0d", obs_data.size(), NB); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      int  ed = exp_data.pop_front(); bit el = exp_last.pop_front();
      int  od = obs_data.pop_front(); bit ol = obs_last.pop_front();
      n_cmp++; if (od != ed || ol != el) begin n_bad++; $display("FAIL sat_beat: got data %0d last %b, required data %0d last %b", od, ol, ed, el); end
    end
    $display("saturation: clipped frame streamed");
  endtask

  task automatic test_drop();
    int cap, d1, d2;
    bit ok;
    clear_obs();
    rdy_mode = 0;
    set_matrix(100, 3);
    push_expected();
    pulse_rv(1'b1, cap);
    set_matrix(555, 0);
    repeat (4) @(posedge clk);
    pulse_rv(1'b1, d1);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop_timeout: got busy stuck, required idle"); end
    n_cmp++; if (drop_q.size() != 1 || drop_q[0] != d1) begin n_bad++; $display("FAIL drop_stream: got %0d pulses, required 1 at %0d", drop_q.size(), d1); end
    n_cmp++; if (obs_data.size() != NB) begin n_bad++; $display("FAIL drop_count: got %0d beats, required %0d", obs_data.size(), NB); end
    n_cmp++; if (done_q.size() != 1) begin n_bad++; $display("FAIL drop_done: got %0d done pulses, required 1", done_q.size()); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      int  ed = exp_data.pop_front(); bit el = exp_last.pop_front();
      int  od = obs_data.pop_front(); bit ol = obs_last.pop_front();
      n_cmp++; if (od != ed || ol != el) begin n_bad++; $display("FAIL drop_beat: got data %0d last %b, required data %0d last %b", od, ol, ed, el); end
    end
    clear_obs();
    repeat (2) @(posedge clk);
    pulse_rv(1'b0, d2);
    repeat (4) @(negedge clk);
    n_cmp++; if (drop_q.size() != 1 || drop_q[0] != d2) begin n_bad++; $display("FAIL drop_disabled: got %0d pulses, required 1 at %0d", drop_q.size(), d2); end
    n_cmp++; if (busy !== 1'b0 || obs_data.size() != 0) begin n_bad++; $display("FAIL drop_nocapture: got busy %b beats %0d, required busy 0 beats 0", busy, obs_data.size()); end
    enable = 1'b1;
    $display("drop: stream-time and disabled results_valid both dropped");
  endtask

  task automatic test_reset_mid();
    int cap;
    bit ok;
    clear_obs();
    rdy_mode = 0;
    set_matrix(0, 1);
    pulse_rv(1'b1, cap);
    repeat (7) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got tvalid %b busy %b, required 0 0", m_axis_tvalid, busy); end
    repeat (20) @(negedge clk);
    n_cmp++; if (done_q.size() != 0) begin n_bad++; $display("FAIL rstmid_done: got %0d done pulses, required 0", done_q.size()); end
    n_cmp++; if (obs_data.size() != 8) begin n_bad++; $display("FAIL rstmid_count: got %0d beats, required 8", obs_data.size()); end
    clear_obs();
    set_matrix(-7, 11);
    push_expected();
    pulse_rv(1'b1, cap);
    wait_idle(ok);
    n_cmp++; if (!ok || obs_data.size() != NB) begin n_bad++; $display("FAIL rstmid_refill: got %0d beats ok %b, required %0d", obs_data.size(), ok, NB); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      int  ed = exp_data.pop_front(); bit el = exp_last.pop_front();
      int  od = obs_data.pop_front(); bit ol = obs_last.pop_front();
      n_cmp++; if (od != ed || ol != el) begin n_bad++; $display("FAIL rstmid_beat: got data %0d last %b, required data %0d last %b", od, ol, ed, el); end
    end
    $display("reset_mid: frame abandoned, next frame clean");
  endtask

  task automatic test_back_to_back();
    int cap, cap2, drop_edge;
    bit ok;
    clear_obs();
    rdy_mode = 0;
    set_matrix(0, 1);
    push_expected();
    pulse_rv(1'b1, cap);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_done_wait: got no done, required done pulse"); end
    set_matrix(-40000, 5000);
    results_valid = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;
    drop_edge = cyc;
    push_expected();
    @(posedge clk); #1;
    cap2 = cyc;
    results_valid = 1'b0;
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout: got busy stuck, required idle"); end
    n_cmp++; if (cap2 != cap + NB + 2) begin n_bad++; $display("FAIL b2b_spacing: got %0d, required %0d", cap2 - cap, NB + 2); end
    n_cmp++; if (drop_q.size() != 1 || drop_q[0] != drop_edge) begin n_bad++; $display("FAIL b2b_drop: got %0d pulses, required 1 at %0d", drop_q.size(), drop_edge); end
    n_cmp++; if (obs_data.size() != 2 * NB) begin n_bad++; $display("FAIL b2b_count: got %0d beats, required %0d", obs_data.size(), 2 * NB); end
    n_cmp++; if (obs_cyc.size() > NB && obs_cyc[NB] != cap2) begin n_bad++; $display("FAIL b2b_first_cycle: got %0d, required %0d", obs_cyc[NB], cap2); end
    n_cmp++; if (done_q.size() != 2) begin n_bad++; $display("FAIL b2b_done: got %0d done pulses, required 2", done_q.size()); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      int  ed = exp_data.pop_front(); bit el = exp_last.pop_front();
      int  od = obs_data.pop_front(); bit ol = obs_last.pop_front();
      n_cmp++; if (od != ed || ol != el) begin n_bad++; $display("FAIL b2b_beat: got data %0d last %b, required data %0d last %b", od, ol, ed, el); end
    end
    $display("back_to_back: frames at edges %0d and %0d", cap, cap2);
  endtask

  initial begin
    set_matrix(0, 0);
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
